// File: rtl/decoder_pkg.sv
// Shared types and constants for the one-hot sequencer: controller states,
// per-load mode encodings and the mode-to-state mapping used on every load.
package decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_ROTL = 3'd2,
    ST_ROTR = 3'd3,
    ST_SCAN = 3'd4
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROTL = 2'b01;
  localparam logic [1:0] MODE_ROTR = 2'b10;
  localparam logic [1:0] MODE_SCAN = 2'b11;

  // Every mode code names a state, so a load never lands in IDLE.
  function automatic state_e modeToState(input logic [1:0] mode);
    state_e result;
    case (mode)
      MODE_HOLD: result = ST_HOLD;
      MODE_ROTL: result = ST_ROTL;
      MODE_ROTR: result = ST_ROTR;
      default:   result = ST_SCAN;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/onehot_sequencer_if.sv
// Load/control and output bundle of the one-hot sequencer. The master side
// issues loads and controls; the slave side is the sequencer itself.
interface onehot_sequencer_if #(
  parameter int N = 3
) ();

  logic              en;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      sel;
  logic [1:0]        mode;
  logic [(1<<N)-1:0] d;
  logic              d_valid;
  logic [N-1:0]      idx;

  modport master (
    output en, clr, in_valid, sel, mode,
    input  in_ready, d, d_valid, idx
  );

  modport slave (
    input  en, clr, in_valid, sel, mode,
    output in_ready, d, d_valid, idx
  );

endinterface

// File: rtl/dwell_counter.sv
// Dwell counter for the SCAN state: counts 0..DWELL-1 while enabled and
// flags the last count so the sequencer knows when to step.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] r_count;

  assign tc = (r_count == LAST);

  // Clear wins over counting; wrap to zero after the last count of a dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      if (tc) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// One-hot sequencer: loads a binary index, then holds, rotates or scans it.
// The one-hot output is decoded from the stored index so it can never
// disagree with idx/d_valid.
module onehot_sequencer #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  onehot_sequencer_if.slave bus
);

  import decoder_pkg::*;

  localparam int           W       = 1 << N;
  localparam logic [N-1:0] IDX_MAX = '1;

  state_e       r_state;
  logic [N-1:0] r_idx;
  logic         r_dValid;

  logic w_accept;
  logic w_countClear;
  logic w_countEn;
  logic w_tc;

  assign bus.in_ready = bus.en;
  assign w_accept     = bus.in_valid & bus.en & ~bus.clr;
  assign w_countClear = bus.en & (bus.clr | w_accept);
  assign w_countEn    = bus.en & (r_state == ST_SCAN);

  assign bus.idx     = r_idx;
  assign bus.d_valid = r_dValid;
  assign bus.d       = r_dValid ? (W'(1) << r_idx) : '0;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .en    (w_countEn),
    .clear (w_countClear),
    .tc    (w_tc)
  );

  // Controller: reset, then clear, then load, then the per-state step;
  // nothing moves while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_dValid <= 1'b0;
    end else if (bus.en) begin
      if (bus.clr) begin
        r_state  <= ST_IDLE;
        r_idx    <= '0;
        r_dValid <= 1'b0;
      end else if (w_accept) begin
        r_state  <= modeToState(bus.mode);
        r_idx    <= bus.sel;
        r_dValid <= 1'b1;
      end else begin
        case (r_state)
          ST_ROTL: r_idx <= r_idx + N'(1);
          ST_ROTR: r_idx <= r_idx - N'(1);
          ST_SCAN: begin
            if (w_tc) begin
              if (r_idx == IDX_MAX) begin
                r_state  <= ST_IDLE;
                r_dValid <= 1'b0;
              end else begin
                r_idx <= r_idx + N'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Self-checking bench for onehot_sequencer (N=3, DWELL=4): a vector table,
// hand-written SCAN/reset sequences and randomized traffic checked against
// an index/tick-based reference model.
module tb_onehot_sequencer;

  localparam int N     = 3;
  localparam int DWELL = 4;

  typedef struct {
    string      name;
    bit         rst;
    bit         en;
    bit         clr;
    bit         inValid;
    logic [2:0] sel;
    logic [1:0] mode;
    logic [7:0] expD;
    logic       expValid;
    logic [2:0] expIdx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   curEn;

  // Reference model: 0 idle, 1 hold, 2 rotl, 3 rotr, 4 scan.
  int mMode;
  int mIdx;
  bit mValid;
  int mScanStart;
  int mScanTicks;

  vec_t vecs[$];

  onehot_sequencer_if #(.N(N)) bus ();

  onehot_sequencer #(
    .N     (N),
    .DWELL (DWELL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Hard stop in case a sequence never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] modelD();
    return mValid ? 8'(1 << mIdx) : 8'h00;
  endfunction

  task automatic modelStep(input bit r, input bit e, input bit c, input bit v,
                           input int sel, input int mode);
    if (r) begin
      mMode = 0; mIdx = 0; mValid = 0;
    end else if (!e) begin
      // frozen
    end else if (c) begin
      mMode = 0; mIdx = 0; mValid = 0;
    end else if (v) begin
      mIdx = sel; mValid = 1; mMode = 1 + mode;
      mScanStart = sel; mScanTicks = 0;
    end else begin
      case (mMode)
        2: mIdx = (mIdx + 1) % 8;
        3: mIdx = (mIdx + 7) % 8;
        4: begin
          mScanTicks++;
          if (mScanStart + mScanTicks / DWELL > 7) begin
            mMode = 0; mValid = 0; mIdx = 7;
          end else begin
            mIdx = mScanStart + mScanTicks / DWELL;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit c, input bit v,
                               input logic [2:0] sel, input logic [1:0] mode);
    rst          = r;
    bus.en       = e;
    bus.clr      = c;
    bus.in_valid = v;
    bus.sel      = sel;
    bus.mode     = mode;
    curEn        = e;
    @(posedge clk);
    #1;
    modelStep(r, e, c, v, int'(sel), int'(mode));
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expD,
                             input logic expValid, input logic [2:0] expIdx);
    checks++;
    if (bus.d !== expD || bus.d_valid !== expValid || bus.idx !== expIdx ||
        bus.in_ready !== curEn) begin
      failures++;
      $display("[TB] FAIL %s: got d=%h v=%b idx=%0d rdy=%b, expected d=%h v=%b idx=%0d rdy=%b",
               name, bus.d, bus.d_valid, bus.idx, bus.in_ready,
               expD, expValid, expIdx, curEn);
    end
  endtask

  task automatic addVec(input string name, input bit r, input bit e, input bit c,
                        input bit v, input logic [2:0] sel, input logic [1:0] mode,
                        input logic [7:0] expD, input logic expValid,
                        input logic [2:0] expIdx);
    vec_t t;
    t.name = name; t.rst = r; t.en = e; t.clr = c; t.inValid = v;
    t.sel = sel; t.mode = mode; t.expD = expD; t.expValid = expValid; t.expIdx = expIdx;
    vecs.push_back(t);
  endtask

  // Main stimulus: table, SCAN stall, reset abort, then random traffic.
  initial begin
    int sixCount;
    int sevenCount;
    bit reached;
    bit stallEn [11] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    rst = 1'b1; bus.en = 1'b0; bus.clr = 1'b0; bus.in_valid = 1'b0;
    bus.sel = '0; bus.mode = '0; curEn = 1'b0;
    mMode = 0; mIdx = 0; mValid = 0; mScanStart = 0; mScanTicks = 0;

    addVec("reset",        1, 0, 0, 0, 3'd0, 2'd0, 8'h00, 0, 3'd0);
    addVec("hold_load",    0, 1, 0, 1, 3'd5, 2'd0, 8'h20, 1, 3'd5);
    for (int i = 0; i < 10; i++)
      addVec("hold_keep",  0, 1, 0, 0, 3'd0, 2'd0, 8'h20, 1, 3'd5);
    addVec("rotl_load",    0, 1, 0, 1, 3'd6, 2'd1, 8'h40, 1, 3'd6);
    addVec("rotl_1",       0, 1, 0, 0, 3'd0, 2'd0, 8'h80, 1, 3'd7);
    addVec("rotl_wrap",    0, 1, 0, 0, 3'd0, 2'd0, 8'h01, 1, 3'd0);
    addVec("rotl_3",       0, 1, 0, 0, 3'd0, 2'd0, 8'h02, 1, 3'd1);
    addVec("rotl_accept",  0, 1, 0, 1, 3'd2, 2'd0, 8'h04, 1, 3'd2);
    addVec("accept_hold1", 0, 1, 0, 0, 3'd0, 2'd0, 8'h04, 1, 3'd2);
    addVec("accept_hold2", 0, 1, 0, 0, 3'd0, 2'd0, 8'h04, 1, 3'd2);
    addVec("clr_over_load",0, 1, 1, 1, 3'd5, 2'd1, 8'h00, 0, 3'd0);
    addVec("idle_stays",   0, 1, 0, 0, 3'd0, 2'd0, 8'h00, 0, 3'd0);
    addVec("rotr_load",    0, 1, 0, 1, 3'd1, 2'd2, 8'h02, 1, 3'd1);
    addVec("rotr_1",       0, 1, 0, 0, 3'd0, 2'd0, 8'h01, 1, 3'd0);
    addVec("rotr_wrap",    0, 1, 0, 0, 3'd0, 2'd0, 8'h80, 1, 3'd7);
    addVec("rotr_3",       0, 1, 0, 0, 3'd0, 2'd0, 8'h40, 1, 3'd6);
    addVec("en0_no_load",  0, 0, 0, 1, 3'd3, 2'd0, 8'h40, 1, 3'd6);
    addVec("en0_no_clr",   0, 0, 1, 0, 3'd0, 2'd0, 8'h40, 1, 3'd6);
    addVec("rotr_resume",  0, 1, 0, 0, 3'd0, 2'd0, 8'h20, 1, 3'd5);
    addVec("rst_en0",      1, 0, 0, 0, 3'd0, 2'd0, 8'h00, 0, 3'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].inValid,
                    vecs[i].sel, vecs[i].mode);
      checkOutput(vecs[i].name, vecs[i].expD, vecs[i].expValid, vecs[i].expIdx);
    end

    // SCAN from 6 with a three-cycle stall inside the first dwell.
    applyStimulus(0, 1, 0, 1, 3'd6, 2'd3);
    checkOutput("scan_load", 8'h40, 1, 3'd6);
    sixCount   = (bus.idx == 3'd6 && bus.d_valid) ? 1 : 0;
    sevenCount = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, stallEn[i], 0, 0, 3'd0, 2'd0);
      checkOutput("scan_step", modelD(), mValid, 3'(mIdx));
      if (bus.d_valid && bus.idx == 3'd6) sixCount++;
      if (bus.d_valid && bus.idx == 3'd7) sevenCount++;
    end
    checks++;
    if (sixCount != 7) begin
      failures++;
      $display("[TB] FAIL scan_stall_len: got %0d cycles at idx 6, expected 7", sixCount);
    end
    checks++;
    if (sevenCount != 4) begin
      failures++;
      $display("[TB] FAIL scan_last_len: got %0d cycles at idx 7, expected 4", sevenCount);
    end
    checkOutput("scan_done", 8'h00, 0, 3'd7);

    // Reset in the middle of a SCAN pass, then a normal load.
    applyStimulus(0, 1, 0, 1, 3'd0, 2'd3);
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (bus.d_valid && bus.idx == 3'd3) begin
        reached = 1;
      end else begin
        applyStimulus(0, 1, 0, 0, 3'd0, 2'd0);
        checkOutput("scan_to_3", modelD(), mValid, 3'(mIdx));
      end
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("[TB] FAIL scan_reach_3: got idx=%0d, expected 3 within 40 cycles", bus.idx);
    end
    applyStimulus(1, 1, 0, 1, 3'd2, 2'd1);
    checkOutput("rst_mid_scan", 8'h00, 0, 3'd0);
    applyStimulus(0, 1, 0, 1, 3'd4, 2'd0);
    checkOutput("load_after_rst", 8'h10, 1, 3'd4);
    applyStimulus(0, 1, 0, 0, 3'd0, 2'd0);
    checkOutput("hold_after_rst", 8'h10, 1, 3'd4);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 5) == 0,
                    3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)));
      checkOutput("random", modelD(), mValid, 3'(mIdx));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
